dmem_port_arbiter: RTL and testbench

//  Shares the single word-addressed data memory between two requesters: port 0 (CPU load/store) and port 1 (DMA/debug loader).

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_port_arbiter_rr_arb2.sv | 17 +
 rtl/dmem_port_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   localparam int   DEPTH    = 128;
   localparam int   IDX_W    = $clog2(DEPTH);
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that was not granted last.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] win
);

   always_comb begin
      win = req;
      if (req == 2'b11) begin
         win = (last == PORT_CPU) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one word-addressed data memory between the CPU and DMA ports,
// one transaction at a time with a fixed grant -> strobe -> done sequence.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req,
   input  logic [1:0]          we,
   input  logic [2*ADDR_W-1:0] addr,
   input  logic [2*DATA_W-1:0] wdata,
   output logic [1:0]          gnt,
   output logic [1:0]          done,
   output logic [DATA_W-1:0]   rdata,
   output logic                err,
   output logic [IDX_W-1:0]    mem_idx,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                mem_rd,
   output logic                mem_wr,
   input  logic [DATA_W-1:0]   mem_rdata
);

   state_t            state;
   logic              last_grant;
   logic              port_q;
   logic              we_q;
   logic              bad_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        win;
   logic              win_port;
   logic              bad;

   function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] word;
      word = a >> 2;
      return (a[1:0] != 2'b00) || (word >= ADDR_W'(DEPTH));
   endfunction

   rr_arb2 u_arb (
      .req  (req),
      .last (last_grant),
      .win  (win)
   );

   assign win_port = win[1];
   assign bad      = addr_bad(addr_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= PORT_DMA;
      end else begin
         case (state)
            IDLE: begin
               if (|win) begin
                  last_grant <= win_port;
                  state      <= ACCESS;
               end
            end
            ACCESS:  state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Transaction latches hold data only; outputs are gated by state, so they need no reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && |win) begin
         port_q  <= win_port;
         we_q    <= we[win_port];
         addr_q  <= win_port ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
         wdata_q <= win_port ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
      end
      if (state == ACCESS) begin
         bad_q <= bad;
      end
   end

   // Reset masks every output in the same cycle, which is what drops an in-flight write.
   always_comb begin
      gnt       = '0;
      done      = '0;
      rdata     = '0;
      err       = 1'b0;
      mem_idx   = '0;
      mem_wdata = '0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: gnt = win;
            ACCESS: begin
               mem_idx   = addr_q[IDX_W+1:2];
               mem_wdata = wdata_q;
               mem_rd    = !bad && !we_q;
               mem_wr    = !bad && we_q;
            end
            RESP: begin
               done[port_q] = 1'b1;
               err          = bad_q;
               if (!we_q && !bad_q) begin
                  rdata = mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small synchronous memory model.
module tb_dmem_port_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [1:0]  gnt;
   logic [1:0]  done;
   logic [31:0] rdata;
   logic        err;
   logic [6:0]  mem_idx;
   logic [31:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:127];
   int compared   = 0;
   int mismatched = 0;
   int rd_cnt     = 0;
   int wr_cnt     = 0;
   int viol       = 0;

   dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .done      (done),
      .rdata     (rdata),
      .err       (err),
      .mem_idx   (mem_idx),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wr) begin
         mem[mem_idx] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (mem_rd) begin
         mem_rdata <= mem[mem_idx];
         rd_cnt <= rd_cnt + 1;
      end
   end

   always @(negedge clk) begin
      assert (!(mem_rd && mem_wr)) else $error("read and write strobes overlap");
      if ((mem_rd && mem_wr) || $countones(gnt) > 1 || $countones(done) > 1 ||
          (int'(|gnt) + int'(|done) + int'(mem_rd | mem_wr) > 1))
         viol++;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 2'b11; we = 2'b01; addr = {32'h4, 32'h8}; wdata = '0;
      step(); sample();
      compared++; if (gnt !== 2'b00) begin mismatched++; $display("FAIL rst_gnt: got %b want 00", gnt); end
      compared++; if (done !== 2'b00) begin mismatched++; $display("FAIL rst_done: got %b want 00", done); end
      compared++; if ({mem_rd, mem_wr} !== 2'b00) begin mismatched++; $display("FAIL rst_strobes: got %b want 00", {mem_rd, mem_wr}); end
      compared++; if ({rdata, err} !== 33'd0) begin mismatched++; $display("FAIL rst_rdata_err: got %h/%b want 0/0", rdata, err); end
      step(); rst = 1'b0; req = 2'b00; we = 2'b00; sample();
      compared++; if (gnt !== 2'b00) begin mismatched++; $display("FAIL rst_idle_gnt: got %b want 00", gnt); end
   endtask

   task automatic test_basic_read();
      step(); req = 2'b01; we = 2'b00; addr = {32'h0, 32'h8}; sample();
      compared++; if (gnt !== 2'b01) begin mismatched++; $display("FAIL rd_gnt: got %b want 01", gnt); end
      compared++; if (mem_rd !== 1'b0) begin mismatched++; $display("FAIL rd_early_strobe: got %b want 0", mem_rd); end
      step(); req = 2'b00; sample();
      compared++; if ({mem_rd, mem_wr} !== 2'b10) begin mismatched++; $display("FAIL rd_strobe: got %b want 10", {mem_rd, mem_wr}); end
      compared++; if (mem_idx !== 7'd2) begin mismatched++; $display("FAIL rd_idx: got %0d want 2", mem_idx); end
      step(); sample();
      compared++; if (done !== 2'b01) begin mismatched++; $display("FAIL rd_done: got %b want 01", done); end
      compared++; if (rdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL rd_data: got %h want deadbeef", rdata); end
      compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL rd_err: got %b want 0", err); end
      step(); sample();
      compared++; if ({done, rdata} !== 34'd0) begin mismatched++; $display("FAIL rd_after: got %b/%h want 00/0", done, rdata); end
   endtask

   task automatic test_boundary_write();
      int wr0;
      wr0 = wr_cnt;
      step(); req = 2'b10; we = 2'b10; addr = {32'h1FC, 32'h0}; wdata = {32'h12345678, 32'h0}; sample();
      compared++; if (gnt !== 2'b10) begin mismatched++; $display("FAIL wr_gnt: got %b want 10", gnt); end
      step(); req = 2'b00; we = 2'b00; sample();
      compared++; if ({mem_rd, mem_wr} !== 2'b01) begin mismatched++; $display("FAIL wr_strobe: got %b want 01", {mem_rd, mem_wr}); end
      compared++; if (mem_idx !== 7'd127) begin mismatched++; $display("FAIL wr_idx: got %0d want 127", mem_idx); end
      compared++; if (mem_wdata !== 32'h12345678) begin mismatched++; $display("FAIL wr_wdata: got %h want 12345678", mem_wdata); end
      step(); sample();
      compared++; if ({done, err, rdata} !== {2'b10, 1'b0, 32'h0}) begin mismatched++; $display("FAIL wr_done: got %b/%b/%h want 10/0/0", done, err, rdata); end
      step(); sample();
      compared++; if (wr_cnt - wr0 !== 1) begin mismatched++; $display("FAIL wr_count: got %0d want 1", wr_cnt - wr0); end
      compared++; if (mem[127] !== 32'h12345678) begin mismatched++; $display("FAIL wr_mem: got %h want 12345678", mem[127]); end
      step(); req = 2'b01; we = 2'b00; addr = {32'h0, 32'h1FC}; sample();
      compared++; if (gnt !== 2'b01) begin mismatched++; $display("FAIL rb_gnt: got %b want 01", gnt); end
      step(); req = 2'b00; sample();
      compared++; if ({mem_rd, mem_idx} !== {1'b1, 7'd127}) begin mismatched++; $display("FAIL rb_strobe: got %b/%0d want 1/127", mem_rd, mem_idx); end
      step(); sample();
      compared++; if ({done, rdata} !== {2'b01, 32'h12345678}) begin mismatched++; $display("FAIL rb_data: got %b/%h want 01/12345678", done, rdata); end
   endtask

   task automatic test_round_robin();
      logic [1:0]  eg;
      logic [1:0]  ed;
      logic [31:0] er;
      int          ndone;
      ndone = 0;
      step(); rst = 1'b1; req = 2'b00; sample();
      step(); rst = 1'b0; req = 2'b11; we = 2'b00; addr = {32'h4, 32'h0};
      for (int i = 0; i < 12; i++) begin
         if (i != 0) step();
         sample();
         eg = (i % 3 == 0) ? (((i / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
         ed = (i % 3 == 2) ? (((i / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
         er = (i % 3 == 2) ? (((i / 3) % 2 == 0) ? 32'h0000AAAA : 32'h0000BBBB) : 32'h0;
         if (done != 2'b00) ndone++;
         compared++; if (gnt !== eg) begin mismatched++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, eg); end
         compared++; if ({done, rdata} !== {ed, er}) begin mismatched++; $display("FAIL rr_done[%0d]: got %b/%h want %b/%h", i, done, rdata, ed, er); end
      end
      compared++; if (ndone !== 4) begin mismatched++; $display("FAIL rr_done_count: got %0d want 4", ndone); end
      step(); req = 2'b00; sample();
      compared++; if (gnt !== 2'b00) begin mismatched++; $display("FAIL rr_release: got %b want 00", gnt); end
   endtask

   task automatic test_bad_addr();
      int rd0;
      int wr0;
      rd0 = rd_cnt; wr0 = wr_cnt;
      step(); req = 2'b01; we = 2'b00; addr = {32'h0, 32'h6}; sample();
      compared++; if (gnt !== 2'b01) begin mismatched++; $display("FAIL mis_gnt: got %b want 01", gnt); end
      step(); req = 2'b00; sample();
      compared++; if ({mem_rd, mem_wr} !== 2'b00) begin mismatched++; $display("FAIL mis_strobe: got %b want 00", {mem_rd, mem_wr}); end
      step(); sample();
      compared++; if ({done, err, rdata} !== {2'b01, 1'b1, 32'h0}) begin mismatched++; $display("FAIL mis_done: got %b/%b/%h want 01/1/0", done, err, rdata); end
      step(); req = 2'b10; we = 2'b10; addr = {32'h200, 32'h0}; wdata = {32'hBADBAD00, 32'h0}; sample();
      compared++; if (gnt !== 2'b10) begin mismatched++; $display("FAIL oor_gnt: got %b want 10", gnt); end
      step(); req = 2'b00; sample();
      compared++; if ({mem_rd, mem_wr} !== 2'b00) begin mismatched++; $display("FAIL oor_strobe: got %b want 00", {mem_rd, mem_wr}); end
      step(); sample();
      compared++; if ({done, err, rdata} !== {2'b10, 1'b1, 32'h0}) begin mismatched++; $display("FAIL oor_done: got %b/%b/%h want 10/1/0", done, err, rdata); end
      step(); req = 2'b01; we = 2'b01; addr = {32'h0, 32'h80000000}; wdata = {32'h0, 32'hFFFFFFFF}; sample();
      compared++; if (gnt !== 2'b01) begin mismatched++; $display("FAIL hi_gnt: got %b want 01", gnt); end
      step(); req = 2'b00; we = 2'b00; sample();
      compared++; if ({mem_rd, mem_wr} !== 2'b00) begin mismatched++; $display("FAIL hi_strobe: got %b want 00", {mem_rd, mem_wr}); end
      step(); sample();
      compared++; if ({done, err} !== {2'b01, 1'b1}) begin mismatched++; $display("FAIL hi_done: got %b/%b want 01/1", done, err); end
      step(); sample();
      compared++; if ({rd_cnt - rd0, wr_cnt - wr0} !== {32'sd0, 32'sd0}) begin mismatched++; $display("FAIL bad_counts: got rd %0d wr %0d want 0 0", rd_cnt - rd0, wr_cnt - wr0); end
      compared++; if (mem[0] !== 32'h0000AAAA) begin mismatched++; $display("FAIL hi_alias: got %h want 0000aaaa", mem[0]); end
   endtask

   task automatic test_reset_abort();
      int wr0;
      wr0 = wr_cnt;
      step(); req = 2'b01; we = 2'b01; addr = {32'h0, 32'h10}; wdata = {32'h0, 32'hCAFEF00D}; sample();
      compared++; if (gnt !== 2'b01) begin mismatched++; $display("FAIL ab_gnt: got %b want 01", gnt); end
      step(); req = 2'b00; we = 2'b00; rst = 1'b1; sample();
      compared++; if ({mem_rd, mem_wr} !== 2'b00) begin mismatched++; $display("FAIL ab_strobe: got %b want 00", {mem_rd, mem_wr}); end
      step(); rst = 1'b0; sample();
      compared++; if ({done, err} !== 3'b000) begin mismatched++; $display("FAIL ab_done: got %b/%b want 00/0", done, err); end
      step(); req = 2'b10; we = 2'b00; addr = {32'h0, 32'h0}; sample();
      compared++; if (gnt !== 2'b10) begin mismatched++; $display("FAIL ab_idle_gnt: got %b want 10", gnt); end
      step(); req = 2'b00; sample();
      compared++; if ({mem_rd, mem_idx} !== {1'b1, 7'd0}) begin mismatched++; $display("FAIL ab_rd: got %b/%0d want 1/0", mem_rd, mem_idx); end
      step(); sample();
      compared++; if ({done, rdata} !== {2'b10, 32'h0000AAAA}) begin mismatched++; $display("FAIL ab_rdata: got %b/%h want 10/0000aaaa", done, rdata); end
      compared++; if (mem[4] !== 32'h11111111) begin mismatched++; $display("FAIL ab_mem: got %h want 11111111", mem[4]); end
      compared++; if (wr_cnt - wr0 !== 0) begin mismatched++; $display("FAIL ab_wr_count: got %0d want 0", wr_cnt - wr0); end
   endtask

   task automatic test_drop_req();
      step(); req = 2'b01; we = 2'b00; addr = {32'h0, 32'hC}; sample();
      compared++; if (gnt !== 2'b01) begin mismatched++; $display("FAIL dr_gnt: got %b want 01", gnt); end
      step(); req = 2'b00; we = 2'b01; addr = {32'h0, 32'h10}; sample();
      compared++; if ({mem_rd, mem_wr, mem_idx} !== {2'b10, 7'd3}) begin mismatched++; $display("FAIL dr_strobe: got %b%b/%0d want 10/3", mem_rd, mem_wr, mem_idx); end
      step(); req = 2'b01; we = 2'b00; sample();
      compared++; if (gnt !== 2'b00) begin mismatched++; $display("FAIL dr_rereq_gnt: got %b want 00", gnt); end
      compared++; if ({done, rdata} !== {2'b01, 32'hA5A5A5A5}) begin mismatched++; $display("FAIL dr_done: got %b/%h want 01/a5a5a5a5", done, rdata); end
      step(); sample();
      compared++; if (gnt !== 2'b01) begin mismatched++; $display("FAIL dr_next_gnt: got %b want 01", gnt); end
      step(); req = 2'b00; sample();
      compared++; if ({mem_rd, mem_idx} !== {1'b1, 7'd4}) begin mismatched++; $display("FAIL dr_next_rd: got %b/%0d want 1/4", mem_rd, mem_idx); end
      step(); sample();
      compared++; if ({done, rdata} !== {2'b01, 32'h11111111}) begin mismatched++; $display("FAIL dr_next_done: got %b/%h want 01/11111111", done, rdata); end
   endtask

   task automatic test_exclusivity();
      step(); sample();
      compared++; if (viol !== 0) begin mismatched++; $display("FAIL exclusivity: got %0d overlapping cycles want 0", viol); end
   endtask

   initial begin
      rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; mem_rdata = '0;
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      mem[0] = 32'h0000AAAA;
      mem[1] = 32'h0000BBBB;
      mem[2] = 32'hDEADBEEF;
      mem[3] = 32'hA5A5A5A5;
      mem[4] = 32'h11111111;
      test_reset();
      test_basic_read();
      test_boundary_write();
      test_round_robin();
      test_bad_addr();
      test_reset_abort();
      test_drop_req();
      test_exclusivity();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
